// File: rtl/spi_flash_read_master.sv
// SPI host read engine: turns an (addr, len, quad) request into a 0x03 single or 0x6B quad-output
// flash read, streaming received bytes out through a one-byte valid/ready register.
module spi_flash_read_master #(
  parameter int ADDR_BITS    = 24,
  parameter int LEN_BITS     = 8,
  parameter int DIV          = 2,
  parameter int DUMMY_CYCLES = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [LEN_BITS-1:0]  req_len,
  input  logic                 req_quad,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [7:0]           resp_data,
  output logic                 resp_last,
  output logic                 busy,
  output logic                 sck,
  output logic                 cs_0,
  output logic [3:0]           dq_out,
  output logic [3:0]           dq_drive,
  input  logic [3:0]           dq_in
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_STALL, S_GAP
  } state_t;

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GAP_W = $clog2(2 * DIV + 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(2 * DIV - 1);
  localparam logic [7:0]       DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

  state_t              state, state_d;
  logic [CNT_W-1:0]    div_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic [7:0]          bit_idx;
  logic [7:0]          seg_last;
  logic [LEN_BITS-1:0] byte_cnt;
  logic [LEN_BITS-1:0] len_q;
  logic                quad_q;
  logic [31:0]         tx_sr;
  logic [7:0]          rx_sr;
  logic [7:0]          rx_nxt;
  logic                active, tick, rise, fall, seg_end, accept;

  assign active  = state inside {S_CMD, S_ADDR, S_DUMMY, S_DATA};
  assign tick    = active && (div_cnt == CNT_LAST);
  assign rise    = tick && !sck;
  assign fall    = tick && sck;
  assign seg_end = fall && (bit_idx == seg_last);
  assign accept  = (state == S_IDLE) && req_valid;
  assign rx_nxt  = quad_q ? {rx_sr[3:0], dq_in} : {rx_sr[6:0], dq_in[1]};
  assign dq_out  = {3'b000, tx_sr[31]};

  // NOTE: every signal written here gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state;
    seg_last  = 8'd0;
    req_ready = 1'b0;
    busy      = 1'b1;
    cs_0      = 1'b0;
    dq_drive  = 4'b0000;
    unique case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        cs_0      = 1'b1;
        if (req_valid) state_d = S_CMD;
      end
      S_CMD: begin
        seg_last = 8'd7;
        dq_drive = 4'b0001;
        if (seg_end) state_d = S_ADDR;
      end
      S_ADDR: begin
        seg_last = 8'd23;
        dq_drive = 4'b0001;
        if (seg_end) state_d = (quad_q && DUMMY_CYCLES > 0) ? S_DUMMY : S_DATA;
      end
      S_DUMMY: begin
        seg_last = DUMMY_LAST;
        if (seg_end) state_d = S_DATA;
      end
      S_DATA: begin
        seg_last = quad_q ? 8'd1 : 8'd7;
        // Byte boundary: finish, or park with sck low while the output byte is still unclaimed.
        if (seg_end) begin
          if (byte_cnt == len_q)              state_d = S_GAP;
          else if (resp_valid && !resp_ready) state_d = S_STALL;
        end
      end
      S_STALL: begin
        if (resp_ready) state_d = S_DATA;
      end
      S_GAP: begin
        cs_0 = 1'b1;
        if (gap_cnt == GAP_LAST && (!resp_valid || resp_ready)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      div_cnt    <= '0;
      gap_cnt    <= '0;
      sck        <= 1'b0;
      bit_idx    <= 8'd0;
      byte_cnt   <= '0;
      len_q      <= '0;
      quad_q     <= 1'b0;
      tx_sr      <= 32'd0;
      rx_sr      <= 8'd0;
      resp_valid <= 1'b0;
      resp_last  <= 1'b0;
      resp_data  <= 8'd0;
    end else begin
      state <= state_d;

      if (active) div_cnt <= tick ? '0 : div_cnt + 1'b1;
      else        div_cnt <= '0;

      if (tick) sck <= ~sck;

      if (fall) begin
        bit_idx <= seg_end ? 8'd0 : bit_idx + 8'd1;
        tx_sr   <= {tx_sr[30:0], 1'b0};
      end

      if (state == S_GAP) gap_cnt <= (gap_cnt == GAP_LAST) ? gap_cnt : gap_cnt + 1'b1;
      else                gap_cnt <= '0;

      if (state == S_DATA && seg_end) byte_cnt <= byte_cnt + 1'b1;

      if (resp_valid && resp_ready) begin
        resp_valid <= 1'b0;
        resp_last  <= 1'b0;
      end

      if (state == S_DATA && rise) begin
        rx_sr <= rx_nxt;
        if (bit_idx == seg_last) begin
          resp_data  <= rx_nxt;
          resp_valid <= 1'b1;
          resp_last  <= (byte_cnt == len_q);
        end
      end

      // Address is zero-extended to the 24 bits sent on the wire.
      if (accept) begin
        len_q    <= req_len;
        quad_q   <= req_quad;
        tx_sr    <= {(req_quad ? 8'h6B : 8'h03), 24'(req_addr)};
        byte_cnt <= '0;
        bit_idx  <= 8'd0;
        sck      <= 1'b0;
      end
    end
  end

endmodule
